// File: rtl/omp_pkg.sv
// Shared types and helpers for the OMP arg-max engine: default widths, FSM
// state encoding and the unsigned-magnitude helper.
package omp_pkg;

    localparam int OMP_DW     = 48;
    localparam int OMP_N_COLS = 64;
    localparam int OMP_IDX_W  = $clog2(OMP_N_COLS);
    localparam int ABS_W      = 64;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    // Two's-complement magnitude; the most negative value maps to its exact
    // unsigned magnitude once the caller keeps the low DW bits.
    function automatic logic [ABS_W-1:0] abs_u(input logic signed [ABS_W-1:0] x);
        return x[ABS_W-1] ? ABS_W'(-x) : ABS_W'(x);
    endfunction

endpackage

// File: rtl/omp_argmax_lane_reduce.sv
// Combinational LANES-to-1 reduction of (magnitude, column, valid) with the
// lowest lane winning ties; also reports which lane won as a one-hot vector.
module omp_argmax_lane_reduce #(
    parameter int DW    = 48,
    parameter int LANES = 4,
    parameter int IDX_W = 6
) (
    input  logic [LANES*DW-1:0]    mag,
    input  logic [LANES*IDX_W-1:0] idx,
    input  logic [LANES-1:0]       valid,
    output logic [DW-1:0]          best_mag,
    output logic [IDX_W-1:0]       best_idx,
    output logic                   best_valid,
    output logic [LANES-1:0]       best_sel
);

    always_comb begin
        best_mag   = '0;
        best_idx   = '0;
        best_valid = 1'b0;
        best_sel   = '0;
        // Strict compare in ascending lane order keeps the lowest lane on ties.
        for (int l = 0; l < LANES; l++) begin
            if (valid[l] && (!best_valid || mag[l*DW +: DW] > best_mag)) begin
                best_mag    = mag[l*DW +: DW];
                best_idx    = idx[l*IDX_W +: IDX_W];
                best_valid  = 1'b1;
                best_sel    = '0;
                best_sel[l] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/omp_argmax_engine.sv
// Streaming masked arg-max of |corr| over N_COLS columns with a support bitmap.
// Define OMP_ARGMAX_RUNNER_UP_EN to add the second-best column tracker and its outputs.
module omp_argmax_engine
    import omp_pkg::*;
#(
    parameter int  DW       = OMP_DW,
    parameter int  N_COLS   = OMP_N_COLS,
    parameter int  LANES    = 4,
    parameter int  MAX_ITER = 16,
    localparam int IDX_W    = $clog2(N_COLS),
    localparam int CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_support,
    input  logic                   start_search,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*DW-1:0]    in_data,
    input  logic [IDX_W-1:0]       in_base_idx,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       lambda,
    output logic [DW-1:0]          max_abs,
    output logic                   all_masked,
    output logic [CNT_W-1:0]       support_cnt,
    output logic                   support_full,
    output logic                   busy
`ifdef OMP_ARGMAX_RUNNER_UP_EN
    ,
    output logic [IDX_W-1:0]       lambda2,
    output logic [DW-1:0]          max_abs2,
    output logic                   runner_up_valid
`endif
);

    localparam int MAP_W = 1 << IDX_W;

    state_t               state, state_nx;
    logic                 drain_cnt;
    logic [MAP_W-1:0]     bitmap;
    logic                 fire, start_acc, commit;

    logic [LANES*DW-1:0]    mag_p0, mag_p1;
    logic [LANES*IDX_W-1:0] idx_p0, idx_p1;
    logic [LANES-1:0]       keep_p0, keep_p1;
    logic                   vld_p1;

    logic [DW-1:0]          bmag_p1;
    logic [IDX_W-1:0]       bidx_p1;
    logic                   bvld_p1;
    logic [LANES-1:0]       bsel_p1;
    logic                   upd;

    logic [DW-1:0]          run_mag_p2;
    logic [IDX_W-1:0]       run_idx_p2;
    logic                   run_vld_p2;

    assign in_ready     = (state == SCAN);
    assign busy         = (state != IDLE);
    assign fire         = in_valid && in_ready;
    assign support_full = (support_cnt == CNT_W'(MAX_ITER));
    assign start_acc    = (state == IDLE) && start_search && !support_full && !clear_support;
    assign commit       = out_valid && out_ready && !all_masked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_search && !support_full) state_nx = SCAN;
            SCAN:    if (fire && in_last)               state_nx = DRAIN;
            DRAIN:   if (drain_cnt)                     state_nx = DONE;
            DONE:    if (out_valid && out_ready)        state_nx = IDLE;
            default:                                    state_nx = IDLE;
        endcase
        if (clear_support) state_nx = IDLE;
    end

    // ---- stage 1: per-lane magnitude and mask ----
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DW-1:0] x;
        logic [ABS_W-1:0]     abs_wide_unused;
        logic [IDX_W:0]       col;

        assign x               = in_data[l*DW +: DW];
        assign abs_wide_unused = abs_u(ABS_W'(x));
        assign col             = {1'b0, in_base_idx} + (IDX_W+1)'(l);
        assign mag_p0[l*DW +: DW]       = abs_wide_unused[DW-1:0];
        assign idx_p0[l*IDX_W +: IDX_W] = col[IDX_W-1:0];
        assign keep_p0[l] = (col < (IDX_W+1)'(N_COLS)) && !bitmap[col[IDX_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= fire && !clear_support;
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            mag_p1  <= mag_p0;
            idx_p1  <= idx_p0;
            keep_p1 <= keep_p0;
        end
    end

    // ---- stage 2: lane reduction and running-max compare ----
    omp_argmax_lane_reduce #(.DW(DW), .LANES(LANES), .IDX_W(IDX_W)) u_reduce (
        .mag        (mag_p1),
        .idx        (idx_p1),
        .valid      (keep_p1),
        .best_mag   (bmag_p1),
        .best_idx   (bidx_p1),
        .best_valid (bvld_p1),
        .best_sel   (bsel_p1)
    );

    assign upd = vld_p1 && bvld_p1 && (!run_vld_p2 || bmag_p1 > run_mag_p2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          run_vld_p2 <= 1'b0;
        else if (clear_support || start_acc) run_vld_p2 <= 1'b0;
        else if (upd)                        run_vld_p2 <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (upd) begin
            run_mag_p2 <= bmag_p1;
            run_idx_p2 <= bidx_p1;
        end
    end

`ifdef OMP_ARGMAX_RUNNER_UP_EN
    logic [DW-1:0]    b2mag_p1, n2_mag, run2_mag_p2;
    logic [IDX_W-1:0] b2idx_p1, n2_idx, run2_idx_p2;
    logic             b2vld_p1, n2_vld, run2_vld_p2;
    logic [LANES-1:0] sel2_unused;

    omp_argmax_lane_reduce #(.DW(DW), .LANES(LANES), .IDX_W(IDX_W)) u_reduce2 (
        .mag        (mag_p1),
        .idx        (idx_p1),
        .valid      (keep_p1 & ~bsel_p1),
        .best_mag   (b2mag_p1),
        .best_idx   (b2idx_p1),
        .best_valid (b2vld_p1),
        .best_sel   (sel2_unused)
    );

    // A new leader demotes the old leader unless the beat's own runner-up beats it.
    always_comb begin
        n2_vld = run2_vld_p2;
        n2_mag = run2_mag_p2;
        n2_idx = run2_idx_p2;
        if (upd) begin
            if (b2vld_p1 && (!run_vld_p2 || b2mag_p1 > run_mag_p2)) begin
                n2_vld = 1'b1;
                n2_mag = b2mag_p1;
                n2_idx = b2idx_p1;
            end else begin
                n2_vld = run_vld_p2;
                n2_mag = run_mag_p2;
                n2_idx = run_idx_p2;
            end
        end else if (vld_p1 && bvld_p1 && (!run2_vld_p2 || bmag_p1 > run2_mag_p2)) begin
            n2_vld = 1'b1;
            n2_mag = bmag_p1;
            n2_idx = bidx_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          run2_vld_p2 <= 1'b0;
        else if (clear_support || start_acc) run2_vld_p2 <= 1'b0;
        else                                 run2_vld_p2 <= n2_vld;
    end

    always_ff @(posedge clk) begin
        run2_mag_p2 <= n2_mag;
        run2_idx_p2 <= n2_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lambda2         <= '0;
            max_abs2        <= '0;
            runner_up_valid <= 1'b0;
        end else if (!clear_support && state == DONE && !out_valid) begin
            lambda2         <= run2_vld_p2 ? run2_idx_p2 : '0;
            max_abs2        <= run2_vld_p2 ? run2_mag_p2 : '0;
            runner_up_valid <= run2_vld_p2;
        end
    end
`else
    logic bsel_unused;
    assign bsel_unused = ^bsel_p1;
`endif

    // ---- result and commit ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            lambda     <= '0;
            max_abs    <= '0;
            all_masked <= 1'b0;
        end else if (clear_support) begin
            out_valid  <= 1'b0;
        end else if (state == DONE && !out_valid) begin
            out_valid  <= 1'b1;
            all_masked <= !run_vld_p2;
            lambda     <= run_vld_p2 ? run_idx_p2 : '0;
            max_abs    <= run_vld_p2 ? run_mag_p2 : '0;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap      <= '0;
            support_cnt <= '0;
        end else if (clear_support) begin
            bitmap      <= '0;
            support_cnt <= '0;
        end else if (commit) begin
            bitmap[lambda] <= 1'b1;
            support_cnt    <= support_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_omp_argmax_engine.sv
// Randomized bench for omp_argmax_engine checked against a column-order
// behavioural model of the masked arg-max and support bookkeeping.
module tb_omp_argmax_engine;

    localparam int DW = 48, N_COLS = 64, LANES = 4, MAX_ITER = 16;
    localparam int IDX_W = 6, CNT_W = 5;

    logic                 clk, rst_n, clear_support, start_search;
    logic                 in_valid, in_ready, in_last, out_valid, out_ready;
    logic [LANES*DW-1:0]  in_data;
    logic [IDX_W-1:0]     in_base_idx, lambda;
    logic [DW-1:0]        max_abs;
    logic                 all_masked, support_full, busy;
    logic [CNT_W-1:0]     support_cnt;
`ifdef OMP_ARGMAX_RUNNER_UP_EN
    logic [IDX_W-1:0]     lambda2;
    logic [DW-1:0]        max_abs2;
    logic                 runner_up_valid;
`endif

    omp_argmax_engine #(.DW(DW), .N_COLS(N_COLS), .LANES(LANES), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst_n(rst_n), .clear_support(clear_support), .start_search(start_search),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_base_idx(in_base_idx),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .lambda(lambda),
        .max_abs(max_abs), .all_masked(all_masked), .support_cnt(support_cnt),
        .support_full(support_full), .busy(busy)
`ifdef OMP_ARGMAX_RUNNER_UP_EN
        , .lambda2(lambda2), .max_abs2(max_abs2), .runner_up_valid(runner_up_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model state
    bit [N_COLS-1:0]        m_bm;
    int                     m_cnt;
    logic signed [DW-1:0]   bd [16][LANES];
    int                     bb [16];
    int                     nb;
    bit                     e_vld, e2_vld, allowed;
    int                     e_idx, e2_idx;
    longint unsigned        e_mag, e2_mag;

    function automatic longint unsigned mag_of(input logic signed [DW-1:0] x);
        longint v;
        v = x;
        return (v < 0) ? longint'(-v) : longint'(v);
    endfunction

    // Visit columns in presentation order; strictly-greater keeps the earliest on ties.
    task automatic model_scan();
        e_vld = 0; e_idx = 0; e_mag = 0;
        e2_vld = 0; e2_idx = 0; e2_mag = 0;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LANES; l++) begin
                int c;
                longint unsigned m;
                c = bb[b] + l;
                if (c >= N_COLS) continue;
                if (m_bm[c]) continue;
                m = mag_of(bd[b][l]);
                if (!e_vld || m > e_mag) begin
                    if (e_vld) begin
                        e2_vld = 1; e2_idx = e_idx; e2_mag = e_mag;
                    end
                    e_vld = 1; e_idx = c; e_mag = m;
                end else if (!e2_vld || m > e2_mag) begin
                    e2_vld = 1; e2_idx = c; e2_mag = m;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!allowed) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                check("lambda", lambda, e_vld ? e_idx : 0);
                check("max_abs", max_abs, e_vld ? e_mag : 0);
                check("all_masked", all_masked, !e_vld);
                check("support_cnt_hold", support_cnt, m_cnt);
`ifdef OMP_ARGMAX_RUNNER_UP_EN
                check("runner_up_valid", runner_up_valid, e2_vld);
                check("lambda2", lambda2, e2_vld ? e2_idx : 0);
                check("max_abs2", max_abs2, e2_vld ? e2_mag : 0);
`endif
            end
        end
    end

    task automatic send_beat(input int b);
        int w;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            @(posedge clk); #1;
        end
        in_valid = 1;
        for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = bd[b][l];
        in_base_idx = IDX_W'(bb[b]);
        in_last = (b == nb - 1);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w == 50) check("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic drive_scan(input string tag, input int hold, input bit junk, input bit pin_en,
                              input int pin_idx, input longint unsigned pin_mag, input bit pin_am);
        model_scan();
        if (pin_en) begin
            check({tag, "_model_idx"}, e_idx, pin_idx);
            check({tag, "_model_mag"}, e_mag, pin_mag);
            check({tag, "_model_am"}, !e_vld, pin_am);
        end
        allowed = 1;
        if (junk) begin
            // Beats offered outside SCAN must be dropped.
            in_valid = 1;
            for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = 48'h7FFF_FFFF_FFFF;
            in_base_idx = 0;
            repeat (2) begin @(posedge clk); #1; end
        end
        start_search = 1;
        @(posedge clk); #1;
        start_search = 0;
        in_valid = 0;
        check({tag, "_busy"}, busy, 1);
        for (int b = 0; b < nb; b++) send_beat(b);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s_latency_%0d", tag, k), out_valid, (k == 3));
        end
        if (pin_en) begin
            check({tag, "_lambda"}, lambda, pin_idx);
            check({tag, "_max_abs"}, max_abs, pin_mag);
            check({tag, "_all_masked"}, all_masked, pin_am);
        end
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        allowed = 0;
        if (e_vld) begin
            m_bm[e_idx] = 1;
            m_cnt++;
        end
        check({tag, "_cnt_after"}, support_cnt, m_cnt);
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    // kind 0: alternating small ramp, 1: equal-magnitude tie, 2: most-negative value,
    // 3: random full range, 4: tie-heavy small set
    task automatic gen(input int kind);
        int vals [5] = '{-7, -3, 0, 3, 7};
        nb = (kind <= 2) ? 16 : $urandom_range(1, 16);
        for (int b = 0; b < nb; b++) begin
            bb[b] = 4 * b;
            for (int l = 0; l < LANES; l++) begin
                int c;
                longint v;
                logic [63:0] r;
                c = 4 * b + l;
                case (kind)
                    0: v = (c % 2) ? -(c * 1000 + 7) : (c * 1000 + 7);
                    1: v = (c % 2) ? -(c * 1000) : (c * 1000);
                    4: v = vals[$urandom_range(0, 4)];
                    default: begin
                        r = {$urandom(), $urandom()};
                        v = longint'($signed(r[47:0]));
                    end
                endcase
                if (kind == 0 && c == 37) v = -5 * (longint'(1) << 26);
                if (kind == 1 && c == 10) v = 3 * (longint'(1) << 26);
                if (kind == 1 && c == 50) v = -3 * (longint'(1) << 26);
                if (kind == 2 && c == 5)  v = -(longint'(1) << 47);
                r = v;
                bd[b][l] = r[47:0];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n = 1; clear_support = 0; start_search = 0; in_valid = 0; in_last = 0;
        out_ready = 0; in_data = '0; in_base_idx = '0;
        m_bm = '0; m_cnt = 0; allowed = 0;
        #2 rst_n = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_cnt", support_cnt, 0);
        check("rst_lambda", lambda, 0);
        check("rst_max_abs", max_abs, 0);
        check("rst_all_masked", all_masked, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        gen(0);
        drive_scan("T1", 0, 1, 1, 37, 64'd335544320, 0);
        drive_scan("T2", 2, 0, 1, 63, 64'd63007, 0);
        gen(1);
        drive_scan("T3", 1, 0, 1, 10, 64'd201326592, 0);
        gen(2);
        drive_scan("EDGE", 0, 0, 1, 5, 64'd140737488355328, 0);

        guard = 0;
        while (m_cnt < MAX_ITER && guard < 60) begin
            gen(($urandom_range(0, 1) == 0) ? 3 : 4);
            drive_scan("RND", $urandom_range(0, 3), 0, 0, 0, 0, 0);
            guard++;
        end

        // T4: full support set blocks a new search until cleared
        check("T4_full", support_full, (m_cnt == MAX_ITER));
        start_search = 1;
        @(posedge clk); #1;
        start_search = 0;
        check("T4_busy_blocked", busy, 0);
        @(posedge clk); #1;
        check("T4_in_ready_blocked", in_ready, 0);
        clear_support = 1;
        @(posedge clk); #1;
        clear_support = 0;
        m_bm = '0; m_cnt = 0;
        check("T4_cnt_cleared", support_cnt, 0);
        check("T4_full_cleared", support_full, 0);

        // T5: lanes past the last column are ignored, then an all-masked scan
        nb = 2; bb[0] = 60; bb[1] = 62;
        bd[0] = '{48'sd1, 48'sd2, 48'sd3, 48'sd4};
        bd[1] = '{48'sd2, 48'sd9, 48'sd1000000, 48'sd1000000};
        drive_scan("T5", 0, 0, 1, 63, 64'd9, 0);
        nb = 1; bb[0] = 63;
        bd[0] = '{48'sd99, 48'sd99, 48'sd99, 48'sd99};
        drive_scan("T5_AM", 0, 0, 1, 0, 64'd0, 1);

        // T6: long back-pressure, then an aborted scan
        gen(3);
        drive_scan("T6_HOLD", 10, 0, 0, 0, 0, 0);
        gen(3);
        nb = 16;
        start_search = 1;
        @(posedge clk); #1;
        start_search = 0;
        send_beat(0);
        send_beat(1);
        clear_support = 1;
        @(posedge clk); #1;
        clear_support = 0;
        m_bm = '0; m_cnt = 0;
        check("T6_abort_busy", busy, 0);
        check("T6_abort_in_ready", in_ready, 0);
        check("T6_abort_cnt", support_cnt, 0);
        repeat (8) begin @(posedge clk); #1; end
        check("T6_no_result", out_valid, 0);

        gen(4);
        drive_scan("POST", 1, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
